// File: rtl/ads868x_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : ads868x_frame_packer
// Purpose  : Buffers ADS868x samples in a small FWFT FIFO and emits fixed-
//            length AXI-Stream frames: sequence word, PPS seconds, sub-second
//            cycle count, then FRAME_LEN samples with tlast on the final one.
// Revision : 1.0  initial release
// ============================================================================
module ads868x_frame_packer #(
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pps,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] stat_overflow_cnt,
  output logic [15:0] stat_frame_cnt
);

  localparam int              c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [15:0]     c_last  = 16'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_SEQ = 3'd1,
    S_HDR_SEC = 3'd2,
    S_HDR_SUB = 3'd3,
    S_DATA    = 3'd4
  } state_t;

  // Timebase and PPS synchronizer
  logic        r_pps_s1, r_pps_s2, r_pps_d;
  logic [31:0] r_sec, r_subsec;
  logic        w_pps_rise;

  // Input side
  logic [15:0] r_in_cnt;
  logic [15:0] r_ovf_cnt;
  logic [31:0] r_ts_sec, r_ts_sub;
  logic        r_tready;
  logic        w_gate, w_wr, w_drop, w_sof_in;

  // FIFO
  logic [32:0]     r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_full, w_empty, w_pop;
  logic [32:0]     w_head;

  // Output FSM
  state_t      r_state;
  logic        r_hdr_valid;
  logic [31:0] r_hdr_data;
  logic [15:0] r_out_cnt;
  logic [15:0] r_seq;
  logic [15:0] r_frame_cnt;

  assign w_pps_rise = r_pps_s2 & ~r_pps_d;

  // Frames already started on the input always run to completion
  assign w_gate   = (r_in_cnt != 16'd0) | enable;
  // Full is judged on the occupancy before any same-cycle pop
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_wr     = s_axis_tvalid & w_gate & ~w_full;
  assign w_drop   = s_axis_tvalid & w_gate & w_full;
  assign w_sof_in = (r_in_cnt == 16'd0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_pop    = (r_state == S_DATA) & ~w_empty & m_axis_tready;

  // Header words come from registers; sample words come straight off the FIFO head
  assign m_axis_tvalid     = (r_state == S_DATA) ? ~w_empty : r_hdr_valid;
  assign m_axis_tdata      = (r_state == S_DATA) ? w_head[31:0] : r_hdr_data;
  assign m_axis_tlast      = (r_state == S_DATA) & ~w_empty & (r_out_cnt == c_last);
  assign s_axis_tready     = r_tready;
  assign stat_overflow_cnt = r_ovf_cnt;
  assign stat_frame_cnt    = r_frame_cnt;

  // Two-stage synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_pps_s1 <= 1'b0;
      r_pps_s2 <= 1'b0;
      r_pps_d  <= 1'b0;
    end else begin
      r_pps_s1 <= pps;
      r_pps_s2 <= r_pps_s1;
      r_pps_d  <= r_pps_s2;
    end
  end

  // Seconds count PPS edges; sub-second counts cycles since the last edge, saturating
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_sec    <= '0;
      r_subsec <= '0;
    end else if (w_pps_rise) begin
      r_sec    <= r_sec + 32'd1;
      r_subsec <= '0;
    end else if (r_subsec != 32'hFFFF_FFFF) begin
      r_subsec <= r_subsec + 32'd1;
    end
  end

  // Input frame position, overflow statistics and timestamp capture on SOF
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_in_cnt  <= '0;
      r_ovf_cnt <= '0;
      r_ts_sec  <= '0;
      r_ts_sub  <= '0;
      r_tready  <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_wr) begin
        r_in_cnt <= (r_in_cnt == c_last) ? 16'd0 : r_in_cnt + 16'd1;
        if (w_sof_in) begin
          r_ts_sec <= r_sec;
          r_ts_sub <= r_subsec;
        end
      end
      if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  // FIFO storage: sample with its SOF flag in bit 32
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_sof_in, s_axis_tdata};
    end
  end

  // FIFO pointers and occupancy; reset flushes the contents
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output sequencer: three header beats, then FRAME_LEN sample beats
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hdr_valid <= 1'b0;
      r_hdr_data  <= '0;
      r_out_cnt   <= '0;
      r_seq       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && w_head[32]) begin
            r_state     <= S_HDR_SEQ;
            r_hdr_valid <= 1'b1;
            r_hdr_data  <= {16'hADC0, r_seq};
          end
        end
        S_HDR_SEQ: begin
          if (m_axis_tready) begin
            r_state    <= S_HDR_SEC;
            r_hdr_data <= r_ts_sec;
          end
        end
        S_HDR_SEC: begin
          if (m_axis_tready) begin
            r_state    <= S_HDR_SUB;
            r_hdr_data <= r_ts_sub;
          end
        end
        S_HDR_SUB: begin
          if (m_axis_tready) begin
            r_state     <= S_DATA;
            r_hdr_valid <= 1'b0;
            r_hdr_data  <= '0;
            r_out_cnt   <= '0;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            if (r_out_cnt == c_last) begin
              r_state     <= S_IDLE;
              r_out_cnt   <= '0;
              r_seq       <= r_seq + 16'd1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_out_cnt <= r_out_cnt + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ads868x_frame_packer.md
# ads868x_frame_packer

Downstream stage of the ADS868x acquisition block. Consumes the 32-bit sample stream (`m_axis_*`) and the `pps` input shared with that block, and buffers samples in a small FIFO. Emits fixed-length AXI-Stream frames to the DMA/fabric: three header words (sequence number, PPS seconds, sub-second cycle count), then `FRAME_LEN` samples, with `tlast` on the final sample.

## Interface
- `FRAME_LEN`, 64: samples per frame, 2..65535. Must be ≥ `FIFO_DEPTH`.
- `FIFO_DEPTH`, 16: sample FIFO depth, power of two, 4..256.
- `aclk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high; all state cleared while high.
- `enable`  in  1  start new frames; sampled only at frame boundaries.
- `pps`  in  1  asynchronous pulse-per-second, rising-edge active.
- `s_axis_tdata`  in  32  ADC sample.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  constant 1 after reset; the block never back-pressures and drops samples on overflow.
- `m_axis_tdata`  out  32  frame word.
- `m_axis_tvalid`  out  1  frame word valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last word of the frame.
- `stat_overflow_cnt`  out  16  dropped samples, saturating.
- `stat_frame_cnt`  out  16  frames fully emitted, wrapping.

## Operation
- **Timebase**
  - `pps` passes through a 2-FF synchronizer, then rising-edge detect.
  - On an edge: `sec` (32b) increments, wrapping; `subsec` (32b) loads 0.
  - Otherwise `subsec` increments and saturates at 0xFFFFFFFF.
- **Input side**
  - A sample is accepted when `s_axis_tvalid` is high and the FIFO is not full.
  - Full is evaluated before any same-cycle pop. A sample arriving while full is dropped, `stat_overflow_cnt` increments, and `in_cnt` does not advance.
  - `in_cnt` counts accepted samples 0..`FRAME_LEN`-1 and wraps.
  - When `in_cnt`==0 and `enable`==0, samples are discarded silently: no overflow count, no FIFO write.
  - When `in_cnt`==0 and `enable`==1, the accepted sample is written with an SOF flag, and {`sec`,`subsec`} of that same cycle is latched into `ts_pend`.
  - Once a frame has started on the input, it runs to completion regardless of `enable`.
  - `FRAME_LEN` ≥ `FIFO_DEPTH` guarantees at most one SOF in the FIFO, so one `ts_pend` register suffices.
- **FIFO**
  - First-word-fall-through, 33 bits wide (sample + SOF flag).
  - A write in cycle n is visible at the head in cycle n+1.
- **Output FSM:** states IDLE, HDR_SEQ, HDR_SEC, HDR_SUB, DATA.
  - IDLE: `m_axis_tvalid`=0. Go to HDR_SEQ when the FIFO is non-empty; the head is always SOF here.
  - HDR_SEQ: `m_axis_tdata` = {16'hADC0, `seq`[15:0]}. On handshake go to HDR_SEC.
  - HDR_SEC: `m_axis_tdata` = `ts_pend` seconds. On handshake go to HDR_SUB.
  - HDR_SUB: `m_axis_tdata` = `ts_pend` sub-second count. On handshake go to DATA and clear `out_cnt`.
  - DATA:
    - `m_axis_tvalid` = FIFO not empty; `m_axis_tdata` = head sample.
    - Each handshake pops the FIFO and increments `out_cnt`.
    - `m_axis_tlast` = 1 when `out_cnt` == `FRAME_LEN`-1.
    - The handshake on the tlast beat increments `seq` and `stat_frame_cnt` and returns to IDLE.
- `m_axis_tlast` is 0 in every header state.
- Once `m_axis_tvalid` is high, it and `m_axis_tdata` stay stable until the handshake.

## Timing
- Reset values:
  - `s_axis_tready`=0 while `rst` is high; 1 from the first cycle after release.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - Both stat counters 0; `seq`, `sec`, `subsec`, `in_cnt`, `out_cnt` 0; FSM in IDLE; FIFO empty.
- Reset asserted mid-frame aborts the frame immediately: the FIFO is flushed and no partial frame or `tlast` is emitted.
- Latency from pps:
  - `pps` rise at cycle p → `sec` updated and `subsec`=0 visible at p+3.
  - A sample accepted at p+3 carries the new second with `subsec`=0.
- Latency through the packer, with `m_axis_tready` held at 1:
  - SOF accepted at cycle n → FSM leaves IDLE at n+1 → HDR_SEQ beat at n+2, HDR_SEC at n+3, HDR_SUB at n+4.
  - First sample beat at n+5.
- Throughput: one word per cycle. Each frame costs 3 header cycles plus 1 IDLE cycle of overhead, absorbed by the FIFO when the input rate is ≤ `FRAME_LEN`/(`FRAME_LEN`+4) of `aclk`.
- Simultaneous FIFO write and pop: both occur, and occupancy is unchanged.

## Test plan
- **Basic frame:** `FRAME_LEN`=4, `enable`=1, samples 0x11..0x14 back-to-back, tready=1 → words ADC00000, sec=0, subsec=(cycle of SOF accept), 0x11, 0x12, 0x13, 0x14 with `tlast` only on 0x14. `stat_frame_cnt`=1.
- **PPS stamping:** pulse `pps` twice, then start a frame 10 cycles after the second effect cycle → header sec=2, subsec=10. A following frame has seq word ADC00001.
- **Backpressure:** tready toggles 1010… during header and data → every word appears exactly once, with tvalid and tdata held stable across stalls.
- **Overflow:** tready=0, push `FIFO_DEPTH`+5 samples continuously → `stat_overflow_cnt`=5. After tready=1, the frame contains the first `FIFO_DEPTH` samples, and the rest of the frame fills from subsequent samples.
- **Enable boundary:** deassert `enable` after sample 2 of a 4-sample frame → the frame completes with `tlast`, later samples are discarded, and `stat_overflow_cnt` does not change. Re-enabling starts the next frame with seq+1.
- **Reset mid-frame:** assert `rst` during the DATA state → outputs go to reset values asynchronously. After release, the next frame has seq 0 and sec 0.
